// File: rtl/ula_pkg.sv
// ula_pkg: shared constants and types for the two-port ALU arbiter.
// ALU op encodings, default datapath width and the per-port buffer state type.
package ula_pkg;

    localparam int ULA_WIDTH = 20;

    localparam logic [1:0] ULA_ADD = 2'b00;
    localparam logic [1:0] ULA_OR  = 2'b01;
    localparam logic [1:0] ULA_AND = 2'b10;
    localparam logic [1:0] ULA_NOT = 2'b11;

    // Response buffer of one requester: empty, or holding an unaccepted result
    typedef enum logic {
        PORT_IDLE = 1'b0,
        PORT_FULL = 1'b1
    } port_state_t;

    // Next buffer state given whether the port is granted and whether it accepts
    function automatic port_state_t port_next(input port_state_t cur,
                                              input logic granted,
                                              input logic accept);
        port_state_t nxt;
        nxt = cur;
        case (cur)
            PORT_IDLE: if (granted) nxt = PORT_FULL;
            PORT_FULL: if (accept && !granted) nxt = PORT_IDLE;
            default:   nxt = PORT_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ula_core.sv
// ula_core: purely combinational ALU shared by both requesters.
// add wraps modulo 2^WIDTH, not ignores opB, zero compares the raw operands.
module ula_core
    import ula_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic [1:0]       ctl,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // Select the operation; the equality flag is independent of the op
    always_comb begin
        result = '0;
        case (ctl)
            ULA_ADD: result = opA + opB;
            ULA_OR:  result = opA | opB;
            ULA_AND: result = opA & opB;
            ULA_NOT: result = ~opA;
            default: result = '0;
        endcase
        zero = (opA == opB);
    end

endmodule

// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin sharing of one ALU between two requesters.
// Each port owns a one-entry response buffer; a port is only granted when its
// buffer is empty or being drained in the same cycle.
// Optional macro ULA_LOCK_EN: a port granted with lock=1 keeps priority until
// it is granted again with lock=0. Without it the lock inputs are ignored.
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             req0,
    input  logic [1:0]       ctl0,
    input  logic [WIDTH-1:0] opA0,
    input  logic [WIDTH-1:0] opB0,
    input  logic             lock0,
    output logic             gnt0,
    output logic             rvalid0,
    input  logic             rready0,
    output logic [WIDTH-1:0] result0,
    output logic             zero0,

    input  logic             req1,
    input  logic [1:0]       ctl1,
    input  logic [WIDTH-1:0] opA1,
    input  logic [WIDTH-1:0] opB1,
    input  logic             lock1,
    output logic             gnt1,
    output logic             rvalid1,
    input  logic             rready1,
    output logic [WIDTH-1:0] result1,
    output logic             zero1
);

    port_state_t      state0_q, state0_d;
    port_state_t      state1_q, state1_d;
    logic             ptr_q, ptr_d;
    logic             elig0, elig1;
    logic             grant_any;
    logic             grant_port;
    logic [1:0]       core_ctl;
    logic [WIDTH-1:0] core_a, core_b;
    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic [WIDTH-1:0] result0_q, result1_q;
    logic             zero0_q, zero1_q;

`ifdef ULA_LOCK_EN
    logic             lock_held_q, lock_held_d;
    logic             lock_port_q, lock_port_d;
    logic             grant_lock;
`else
    logic             unused_lock;
    assign unused_lock = lock0 | lock1;
`endif

    assign rvalid0 = (state0_q == PORT_FULL);
    assign rvalid1 = (state1_q == PORT_FULL);
    assign result0 = result0_q;
    assign result1 = result1_q;
    assign zero0   = zero0_q;
    assign zero1   = zero1_q;

    // Decide eligibility and issue at most one grant; nothing is granted in reset
    always_comb begin
        elig0 = req0 && (!rvalid0 || rready0);
        elig1 = req1 && (!rvalid1 || rready1);
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        if (!reset) begin
            if (elig0 && elig1) begin
                if (ptr_q == 1'b0) gnt0 = 1'b1;
                else               gnt1 = 1'b1;
            end else if (elig0) begin
                gnt0 = 1'b1;
            end else if (elig1) begin
                gnt1 = 1'b1;
            end
        end
        grant_any  = gnt0 | gnt1;
        grant_port = gnt1;
    end

    // Route the granted port's op and operands into the shared ALU
    always_comb begin
        core_ctl = ctl0;
        core_a   = opA0;
        core_b   = opB0;
        if (grant_port) begin
            core_ctl = ctl1;
            core_a   = opA1;
            core_b   = opB1;
        end
    end

    ula_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .ctl    (core_ctl),
        .opA    (core_a),
        .opB    (core_b),
        .result (core_result),
        .zero   (core_zero)
    );

`ifdef ULA_LOCK_EN
    // Rotate the priority pointer, unless a lock pins it to its owner
    always_comb begin
        ptr_d       = ptr_q;
        lock_held_d = lock_held_q;
        lock_port_d = lock_port_q;
        grant_lock  = grant_port ? lock1 : lock0;
        if (grant_any) begin
            if (grant_lock) begin
                ptr_d       = grant_port;
                lock_held_d = 1'b1;
                lock_port_d = grant_port;
            end else if (lock_held_q && (lock_port_q == grant_port)) begin
                ptr_d       = ~grant_port;
                lock_held_d = 1'b0;
            end else if (lock_held_q) begin
                ptr_d       = lock_port_q;
            end else begin
                ptr_d       = ~grant_port;
            end
        end
    end
`else
    // Rotate the priority pointer away from whichever port was just served
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) ptr_d = ~grant_port;
    end
`endif

    // Per-port buffer state: fill on grant, empty on accept without refill
    always_comb begin
        state0_d = port_next(state0_q, gnt0, rready0);
        state1_d = port_next(state1_q, gnt1, rready1);
    end

    // Arbitration and buffer state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state0_q <= PORT_IDLE;
            state1_q <= PORT_IDLE;
            ptr_q    <= 1'b0;
        end else begin
            state0_q <= state0_d;
            state1_q <= state1_d;
            ptr_q    <= ptr_d;
        end
    end

`ifdef ULA_LOCK_EN
    // Lock ownership registers
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_held_q <= 1'b0;
            lock_port_q <= 1'b0;
        end else begin
            lock_held_q <= lock_held_d;
            lock_port_q <= lock_port_d;
        end
    end
`endif

    // Capture the ALU result into the granted port's response buffer
    always_ff @(posedge clock) begin
        if (reset) begin
            result0_q <= '0;
            result1_q <= '0;
            zero0_q   <= 1'b0;
            zero1_q   <= 1'b0;
        end else begin
            if (gnt0) begin
                result0_q <= core_result;
                zero0_q   <= core_zero;
            end
            if (gnt1) begin
                result1_q <= core_result;
                zero1_q   <= core_zero;
            end
        end
    end

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Shares one execute-stage ALU (20-bit; add/or/and/not) between two requesters, e.g. the pipeline EX stage (port 0) and a multicycle/debug unit (port 1).
- Round-robin arbitration; operands are captured on grant.
- The result is registered and held in a per-port response buffer until the port accepts it.
- At most one outstanding response per requester.

Parameters:
- WIDTH, 20, operand/result width in bits.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0  input  1  port 0 request; held with stable operands until gnt0
- ctl0  input  2  port 0 ALU op: 00 add, 01 or, 10 and, 11 not opA
- opA0  input  WIDTH  port 0 operand A
- opB0  input  WIDTH  port 0 operand B
- lock0  input  1  port 0 keep-priority request (used only with ULA_LOCK_EN)
- gnt0  output  1  port 0 grant pulse, combinational, same cycle as acceptance
- rvalid0  output  1  port 0 response valid
- rready0  input  1  port 0 response accept
- result0  output  WIDTH  port 0 result
- zero0  output  1  port 0 equality flag, (opA0==opB0)
- req1, ctl1, opA1, opB1, lock1, gnt1, rvalid1, rready1, result1, zero1: same as port 0, for port 1.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high, on port reset.
- Reset values: rvalid0/1=0, result0/1=0, zero0/1=0, priority pointer=0 (port 0 favoured), lock state cleared. gnt0/1 are combinational and read 0 while reset=1.
- Eligibility: port i is eligible when req_i=1 and the response buffer is free (rvalid_i=0, or rvalid_i=1 with rready_i=1 in the same cycle, i.e. drain and refill).
- Arbitration, per cycle:
  - Only one eligible port: it is granted.
  - Both eligible: the port named by the priority pointer wins.
  - After a grant the pointer moves to the other port (round robin).
  - No grant: the pointer is unchanged.
  - At most one gnt per cycle.
- Grant cycle: the ALU (via ula_core) computes from the granted port's ctl/opA/opB. At the next edge, result_i/zero_i are registered and rvalid_i is set.
- Latency: one cycle, from gnt_i high to rvalid_i high.
- Response hold: rvalid_i stays 1 and result_i/zero_i stay stable until a cycle with rready_i=1. At that edge rvalid_i clears, unless a new grant to port i occurred in the same cycle, in which case the new result loads.
- Arithmetic:
  - add wraps modulo 2^WIDTH; no carry out.
  - not ignores opB.
  - zero compares the raw operands, not the result.
- Blocked requester: a requester with a full buffer and rready=0 is skipped. The other port may be granted every cycle.
- Reset mid-operation: pending responses are discarded, with no rvalid afterwards. A request held through reset is re-arbitrated from pointer=0.
- Port states: each port has IDLE (rvalid=0) and FULL (rvalid=1).
  - IDLE→FULL on grant.
  - FULL→IDLE on rready without a new grant.
  - FULL→FULL on rready together with a new grant.

Optional Feature:
- Macro: ULA_LOCK_EN.
- Defined: if the granted port has lock_i=1 in its grant cycle, the pointer stays on that port instead of rotating. The port keeps priority for back-to-back operations until it is granted with lock_i=0. A locked port is still skipped while its buffer is full. In that case the other port may be granted, and the lock is retained.
- Undefined: lock0/lock1 are ignored; pure round robin.

Decomposition:
- Package ula_pkg:
  - Op constants: ULA_ADD=2'b00, ULA_OR=2'b01, ULA_AND=2'b10, ULA_NOT=2'b11.
  - ULA_WIDTH default 20.
- Sub-module ula_core: purely combinational (ctl, opA, opB → result, zero), instantiated once and fed by the grant mux.

Test Plan:
- Single port: req0, ctl0=00, opA0=1, opB0=1 → gnt0 that cycle; next cycle rvalid0=1, result0=2, zero0=1.
- Contention: req0 and req1 both held after reset, rready=1 → grants alternate gnt0, gnt1, gnt0, … Port 1 op or (0xFFC00, 0x00003) gives result1=0xFFC03, zero1=0.
- Backpressure: port 0 gets and (0x00205, 0x0000F) → result0=0x00005. Hold rready0=0 for 5 cycles with req0 still high → no further gnt0, result0 stable at 0x00005, port 1 served every cycle. Then rready0=1 → drain and regrant in the same cycle.
- Wrap and not: add 0xFFFFF+0x00001 → result=0x00000, zero=0. not opA=0xFFC00 → result=0x003FF.
- Reset mid-op: assert reset in the cycle after gnt1 → rvalid1=0 on the next edge and stays 0. Pointer back to 0: with both requesting, the first grant is port 0.
- ULA_LOCK_EN: port 1 granted with lock1=1, both requesting, rready=1 → gnt1 repeats until lock1=0, then port 0 is granted next.
